gpio_port_pcint: RTL and testbench

//  Parametrised GPIO port. Successor to the fixed 8-bit per-port wrappers.

---
 rtl/gpio_port_pcint.sv | 171 +++++++++++++++++
 tb/tb_gpio_port_pcint.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_pcint.sv
// Parametrised GPIO port with PORTx/DDRx/PINx, pin-change mask and
// a single PCIF flag bit. The alternate-function override vectors from
// peripherals are folded into the per-pin pad muxes. Tristate pad
// drive is resolved at the top level.

// Per-pin pad mux: pull-up, direction, drive value, input disable.
module gpio_pin_mux (
    input  logic port_i,
    input  logic ddr_i,
    input  logic pud_i,
    input  logic sleep_i,
    input  logic puoe_i,
    input  logic puov_i,
    input  logic ddoe_i,
    input  logic ddov_i,
    input  logic pvoe_i,
    input  logic pvov_i,
    input  logic dieoe_i,
    input  logic dieov_i,
    output logic pu_o,
    output logic dd_o,
    output logic pval_o,
    output logic die_o
);
    logic pu_n;

    // Pull-up is active only for an input pin with PORTx=1 and no global disable.
    assign pu_n   = puoe_i ? puov_i : (port_i & ~ddr_i & ~pud_i);
    assign pu_o   = ~pu_n;
    assign dd_o   = ddoe_i ? ddov_i : ddr_i;
    assign pval_o = pvoe_i ? pvov_i : port_i;
    // DIEOV is an enable value, die_o is a disable, hence the inversion.
    assign die_o  = dieoe_i ? ~dieov_i : sleep_i;
endmodule

module gpio_port_pcint #(
    parameter int         WIDTH       = 8,
    parameter logic [5:0] PINX_ADDR   = 6'h03,
    parameter logic [5:0] DDRX_ADDR   = 6'h04,
    parameter logic [5:0] PORTX_ADDR  = 6'h05,
    parameter logic [5:0] PCMSK_ADDR  = 6'h2B,
    parameter logic [5:0] PCIFR_ADDR  = 6'h1B,
    parameter int         PCIF_BIT    = 0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic [5:0]       IO_Addr,
    input  logic             iore,
    input  logic             iowe,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       dbus_out,
    output logic             out_en,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] din_o,
    input  logic [WIDTH-1:0] puoe,
    input  logic [WIDTH-1:0] puov,
    input  logic [WIDTH-1:0] ddoe,
    input  logic [WIDTH-1:0] ddov,
    input  logic [WIDTH-1:0] pvoe,
    input  logic [WIDTH-1:0] pvov,
    input  logic [WIDTH-1:0] dieoe,
    input  logic [WIDTH-1:0] dieov,
    input  logic             PUD,
    input  logic             SLEEP,
    input  logic             pcie,
    input  logic             pcif_ack,
    output logic             pcint_irq,
    output logic [WIDTH-1:0] pu_o,
    output logic [WIDTH-1:0] dd_o,
    output logic [WIDTH-1:0] pv_o,
    output logic [WIDTH-1:0] die_o
);
    logic [WIDTH-1:0] port_q, port_d;
    logic [WIDTH-1:0] ddr_q, ddr_d;
    logic [WIDTH-1:0] pcmsk_q, pcmsk_d;
    logic             pcif_q, pcif_d;
    logic [WIDTH-1:0] prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] pval;
    logic [WIDTH-1:0] chg;

    logic hit_pin, hit_ddr, hit_port, hit_msk, hit_ifr;

    assign hit_pin  = (IO_Addr == PINX_ADDR);
    assign hit_ddr  = (IO_Addr == DDRX_ADDR);
    assign hit_port = (IO_Addr == PORTX_ADDR);
    assign hit_msk  = (IO_Addr == PCMSK_ADDR);
    assign hit_ifr  = (IO_Addr == PCIFR_ADDR);

    // One pad mux per pin; the z drive for input pins is applied here.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_mux u_mux (
            .port_i  (port_q[i]),
            .ddr_i   (ddr_q[i]),
            .pud_i   (PUD),
            .sleep_i (SLEEP),
            .puoe_i  (puoe[i]),
            .puov_i  (puov[i]),
            .ddoe_i  (ddoe[i]),
            .ddov_i  (ddov[i]),
            .pvoe_i  (pvoe[i]),
            .pvov_i  (pvov[i]),
            .dieoe_i (dieoe[i]),
            .dieov_i (dieov[i]),
            .pu_o    (pu_o[i]),
            .dd_o    (dd_o[i]),
            .pval_o  (pval[i]),
            .die_o   (die_o[i])
        );
        assign pv_o[i] = dd_o[i] ? pval[i] : 1'bz;
    end

    assign din_o     = sync_q[SYNC_STAGES-1];
    assign chg       = (din_o ^ prev_q) & pcmsk_q;
    assign pcint_irq = pcif_q & pcie;
    assign out_en    = iore & (hit_pin | hit_ddr | hit_port | hit_msk | hit_ifr);

    // Register writes and flag update; a new change beats any clear.
    always_comb begin
        port_d  = port_q;
        ddr_d   = ddr_q;
        pcmsk_d = pcmsk_q;
        pcif_d  = pcif_q;
        if (iowe) begin
            if (hit_port) port_d  = dbus_in[WIDTH-1:0];
            if (hit_pin)  port_d  = port_q ^ dbus_in[WIDTH-1:0];
            if (hit_ddr)  ddr_d   = dbus_in[WIDTH-1:0];
            if (hit_msk)  pcmsk_d = dbus_in[WIDTH-1:0];
        end
        if (pcif_ack || (iowe && hit_ifr && dbus_in[PCIF_BIT])) pcif_d = 1'b0;
        if (|chg) pcif_d = 1'b1;
    end

    // Read mux; unused upper bits stay zero for narrow ports.
    always_comb begin
        dbus_out = '0;
        if (hit_pin)  dbus_out[WIDTH-1:0] = din_o;
        if (hit_ddr)  dbus_out[WIDTH-1:0] = ddr_q;
        if (hit_port) dbus_out[WIDTH-1:0] = port_q;
        if (hit_msk)  dbus_out[WIDTH-1:0] = pcmsk_q;
        if (hit_ifr)  dbus_out[PCIF_BIT]  = pcif_q;
    end

    // Control/status register state.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            port_q  <= '0;
            ddr_q   <= '0;
            pcmsk_q <= '0;
            pcif_q  <= 1'b0;
        end else begin
            port_q  <= port_d;
            ddr_q   <= ddr_d;
            pcmsk_q <= pcmsk_d;
            pcif_q  <= pcif_d;
        end
    end

    // Input synchroniser; disabled pins are gated to 0 before the first flop.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin_i & ~die_o;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= din_o;
        end
    end
endmodule

// File: tb/tb_gpio_port_pcint.sv
// Directed bench for gpio_port_pcint (default parameters).
module tb_gpio_port_pcint;
    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore, iowe;
    logic [7:0] dbus_in, dbus_out;
    logic       out_en;
    logic [7:0] pin_i, din_o;
    logic [7:0] puoe, puov, ddoe, ddov, pvoe, pvov, dieoe, dieov;
    logic       PUD, SLEEP, pcie, pcif_ack, pcint_irq;
    logic [7:0] pu_o, dd_o, pv_o, die_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] rd;

    gpio_port_pcint dut (
        .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
        .pin_i(pin_i), .din_o(din_o),
        .puoe(puoe), .puov(puov), .ddoe(ddoe), .ddov(ddov),
        .pvoe(pvoe), .pvov(pvov), .dieoe(dieoe), .dieov(dieov),
        .PUD(PUD), .SLEEP(SLEEP), .pcie(pcie), .pcif_ack(pcif_ack),
        .pcint_irq(pcint_irq), .pu_o(pu_o), .dd_o(dd_o), .pv_o(pv_o), .die_o(die_o)
    );

    always #5 cp2 = ~cp2;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance one edge, land 1 time unit after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge cp2);
            #1;
        end
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        IO_Addr = a; dbus_in = d; iowe = 1'b1;
        tick(1);
        iowe = 1'b0;
    endtask

    task automatic io_read(input logic [5:0] a, output logic [7:0] d);
        IO_Addr = a; iore = 1'b1;
        #2;
        d = dbus_out;
        iore = 1'b0;
    endtask

    task automatic test_reset;
        ireset = 1'b0;
        #23;
        ireset = 1'b1;
        tick(1);
        io_read(6'h05, rd); checks++;
        if (rd !== 8'h00) begin failures++; $display("FAIL reset_port got=%h exp=00", rd); end
        io_read(6'h04, rd); checks++;
        if (rd !== 8'h00) begin failures++; $display("FAIL reset_ddr got=%h exp=00", rd); end
        IO_Addr = 6'h2B; iore = 1'b1; #2; checks++;
        if (dbus_out !== 8'h00 || out_en !== 1'b1) begin
            failures++; $display("FAIL reset_pcmsk got=%h/%b exp=00/1", dbus_out, out_en);
        end
        IO_Addr = 6'h10; #1; checks++;
        if (out_en !== 1'b0) begin failures++; $display("FAIL unowned_out_en got=%b exp=0", out_en); end
        iore = 1'b0; checks++;
        if (pu_o !== 8'hFF || dd_o !== 8'h00 || pcint_irq !== 1'b0 || din_o !== 8'h00 || die_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs pu=%h dd=%h irq=%b din=%h die=%h exp FF 00 0 00 00",
                     pu_o, dd_o, pcint_irq, din_o, die_o);
        end
    endtask

    task automatic test_pin_toggle;
        io_write(6'h04, 8'h0F);
        io_write(6'h05, 8'hA5);
        io_write(6'h03, 8'h81);
        io_read(6'h05, rd); checks++;
        if (rd !== 8'h24) begin failures++; $display("FAIL pin_toggle got=%h exp=24", rd); end
        checks++;
        if (pv_o[3:0] !== 4'h4 || dd_o !== 8'h0F) begin
            failures++; $display("FAIL pad_drive pv=%h dd=%h exp pv[3:0]=4 dd=0F", pv_o[3:0], dd_o);
        end
        // PORTx=24 with pins 7:4 as inputs: only bit 5 has its pull-up on.
        checks++;
        if (pu_o !== 8'hDF) begin failures++; $display("FAIL pullup_mix got=%h exp=DF", pu_o); end
    endtask

    task automatic test_back_to_back;
        io_write(6'h05, 8'h3C);
        io_write(6'h03, 8'hFF);
        io_write(6'h03, 8'h0F);
        io_read(6'h05, rd); checks++;
        if (rd !== 8'hCC) begin failures++; $display("FAIL b2b_toggle got=%h exp=CC", rd); end
    endtask

    task automatic test_pullup_override;
        io_write(6'h04, 8'h00);
        io_write(6'h05, 8'hFF);
        PUD = 1'b0; #1; checks++;
        if (pu_o !== 8'h00) begin failures++; $display("FAIL pu_enabled got=%h exp=00", pu_o); end
        PUD = 1'b1; #1; checks++;
        if (pu_o !== 8'hFF) begin failures++; $display("FAIL pu_pud got=%h exp=FF", pu_o); end
        puoe = 8'h01; puov = 8'h01; #1; checks++;
        if (pu_o !== 8'hFE) begin failures++; $display("FAIL pu_override got=%h exp=FE", pu_o); end
        ddoe = 8'h80; ddov = 8'h80; pvoe = 8'h80; pvov = 8'h00; #1; checks++;
        if (dd_o !== 8'h80 || pv_o[7] !== 1'b0) begin
            failures++; $display("FAIL dd_pv_override dd=%h pv7=%b exp 80 0", dd_o, pv_o[7]);
        end
        puoe = 0; puov = 0; ddoe = 0; ddov = 0; pvoe = 0; pvov = 0; PUD = 1'b0;
        io_write(6'h05, 8'h00);
    endtask

    task automatic test_pcint_latency;
        io_write(6'h2B, 8'h04);
        pcie = 1'b1;
        pin_i = 8'h04;
        tick(1); checks++;
        if (din_o !== 8'h00 || pcint_irq !== 1'b0) begin
            failures++; $display("FAIL lat_edge1 din=%h irq=%b exp 00 0", din_o, pcint_irq);
        end
        tick(1); checks++;
        if (din_o !== 8'h04 || pcint_irq !== 1'b0) begin
            failures++; $display("FAIL lat_edge2 din=%h irq=%b exp 04 0", din_o, pcint_irq);
        end
        tick(1); checks++;
        if (pcint_irq !== 1'b1) begin failures++; $display("FAIL lat_edge3 irq=%b exp 1", pcint_irq); end
        io_read(6'h1B, rd); checks++;
        if (rd !== 8'h01) begin failures++; $display("FAIL pcifr_read got=%h exp=01", rd); end
        io_write(6'h1B, 8'h01); checks++;
        if (pcint_irq !== 1'b0) begin failures++; $display("FAIL w1c_clear irq=%b exp 0", pcint_irq); end
        pin_i = 8'h0C;
        tick(5); checks++;
        if (pcint_irq !== 1'b0) begin failures++; $display("FAIL unmasked_pin irq=%b exp 0", pcint_irq); end
        pin_i = 8'h04;
        tick(4);
    endtask

    task automatic test_set_wins;
        pin_i = 8'h00;
        tick(3); checks++;
        if (pcint_irq !== 1'b1) begin failures++; $display("FAIL fall_sets irq=%b exp 1", pcint_irq); end
        pcie = 1'b0; #1; checks++;
        if (pcint_irq !== 1'b0) begin failures++; $display("FAIL pcie_gate irq=%b exp 0", pcint_irq); end
        pcie = 1'b1;
        pcif_ack = 1'b1;
        tick(1);
        pcif_ack = 1'b0; checks++;
        if (pcint_irq !== 1'b0) begin failures++; $display("FAIL ack_clear irq=%b exp 0", pcint_irq); end
        pin_i = 8'h04;
        tick(1);
        io_write(6'h1B, 8'h01);   // let flag set by a first change
        tick(1);
        // Flag now set; new change reaches din_o two edges after the pin moves.
        pin_i = 8'h00;
        tick(2);
        pcif_ack = 1'b1;
        tick(1);
        pcif_ack = 1'b0; checks++;
        if (pcint_irq !== 1'b1) begin failures++; $display("FAIL set_wins irq=%b exp 1", pcint_irq); end
        io_write(6'h1B, 8'h01);
        io_read(6'h1B, rd); checks++;
        if (rd !== 8'h00 || pcint_irq !== 1'b0) begin
            failures++; $display("FAIL post_w1c pcifr=%h irq=%b exp 00 0", rd, pcint_irq);
        end
    endtask

    task automatic test_sleep_die;
        pin_i = 8'h04;
        tick(3);
        io_write(6'h1B, 8'h01);
        SLEEP = 1'b1; #1; checks++;
        if (die_o !== 8'hFF) begin failures++; $display("FAIL sleep_die got=%h exp=FF", die_o); end
        tick(3); checks++;
        if (pcint_irq !== 1'b1) begin failures++; $display("FAIL die_fall_chg irq=%b exp 1", pcint_irq); end
        io_read(6'h03, rd); checks++;
        if (rd !== 8'h00) begin failures++; $display("FAIL sleep_pinx got=%h exp=00", rd); end
        io_write(6'h1B, 8'h01);
        dieoe = 8'h04; dieov = 8'h04; #1; checks++;
        if (die_o !== 8'hFB) begin failures++; $display("FAIL die_override got=%h exp=FB", die_o); end
        tick(2);
        io_read(6'h03, rd); checks++;
        if (rd !== 8'h04) begin failures++; $display("FAIL die_pinx got=%h exp=04", rd); end
        tick(1); checks++;
        if (pcint_irq !== 1'b1) begin failures++; $display("FAIL die_ovr_irq irq=%b exp 1", pcint_irq); end
    endtask

    task automatic test_async_reset;
        io_write(6'h05, 8'h5A);
        #2;
        ireset = 1'b0;
        #1; checks++;
        if (pcint_irq !== 1'b0 || din_o !== 8'h00 || pu_o !== 8'hFF) begin
            failures++; $display("FAIL async_rst irq=%b din=%h pu=%h exp 0 00 FF", pcint_irq, din_o, pu_o);
        end
        io_read(6'h05, rd); checks++;
        if (rd !== 8'h00) begin failures++; $display("FAIL async_rst_port got=%h exp=00", rd); end
        @(posedge cp2); #1;
        ireset = 1'b1;
        tick(5); checks++;
        if (pcint_irq !== 1'b0) begin failures++; $display("FAIL post_rst_glitch irq=%b exp 0", pcint_irq); end
        io_read(6'h2B, rd); checks++;
        if (rd !== 8'h00) begin failures++; $display("FAIL post_rst_pcmsk got=%h exp=00", rd); end
    endtask

    initial begin
        ireset = 1'b0; IO_Addr = '0; iore = 0; iowe = 0; dbus_in = '0;
        pin_i = '0; puoe = 0; puov = 0; ddoe = 0; ddov = 0; pvoe = 0; pvov = 0;
        dieoe = 0; dieov = 0; PUD = 0; SLEEP = 0; pcie = 0; pcif_ack = 0;
        test_reset();
        test_pin_toggle();
        test_back_to_back();
        test_pullup_override();
        test_pcint_latency();
        test_set_wins();
        test_sleep_die();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
